// File: rtl/mdio_responder.sv
// mdio_responder: Clause 22 MDIO slave with a 32x16 register file and ID registers 2/3.
// MDC and MDIO are oversampled on Clk; all protocol work happens on a detected MDC rise.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1560
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MDC,
  input  logic        MDIO_I,
  output logic        MDIO_O,
  output logic        MDIO_OE,
  output logic        Wr_Valid,
  output logic [4:0]  Wr_Addr,
  output logic [15:0] Wr_Data
);
  typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA} state_t;
  state_t      state_q;
  logic [1:0]  mdc_q, mdio_q;
  logic        mdc_prev_q;
  logic [5:0]  pre_q;
  logic [3:0]  cnt_q;
  logic        op_q, rd_q;
  logic [4:0]  phy_q, reg_q;
  logic [15:0] sh_q;
  logic [15:0] rf_q [32];
  logic        mdc_rise, b, match;
  logic [4:0]  reg_d;
  logic [15:0] sh_d, rd_word;
  assign mdc_rise = mdc_q[1] & ~mdc_prev_q;
  assign b        = mdio_q[1];
  assign match    = phy_q == PHY_ADDR;
  assign reg_d    = {reg_q[3:0], b};
  assign sh_d     = {sh_q[14:0], b};
  assign rd_word  = reg_d == 5'd2 ? PHY_ID1 : reg_d == 5'd3 ? PHY_ID2 : rf_q[reg_d];
  always_ff @(posedge Clk) begin
    Wr_Valid <= 1'b0;
    if (Rst) begin
      state_q    <= IDLE;
      mdc_q      <= '0;
      mdio_q     <= '0;
      mdc_prev_q <= 1'b0;
      pre_q      <= '0;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      rd_q       <= 1'b0;
      phy_q      <= '0;
      reg_q      <= '0;
      sh_q       <= '0;
      MDIO_O     <= 1'b1;
      MDIO_OE    <= 1'b0;
      Wr_Addr    <= '0;
      Wr_Data    <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      mdc_q      <= {mdc_q[0], MDC};
      mdio_q     <= {mdio_q[0], MDIO_I};
      mdc_prev_q <= mdc_q[1];
      if (mdc_rise) begin
        case (state_q)
          IDLE: begin
            // Saturating run of ones; the first 0 after >=32 ones is ST bit 0.
            pre_q <= b ? pre_q + {5'd0, ~&pre_q} : '0;
            if (!b && pre_q[5]) state_q <= ST;
          end
          ST: begin
            state_q <= b ? OP : IDLE;
            cnt_q   <= 4'd1;
          end
          OP: begin
            op_q  <= b;
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
              state_q <= (op_q ^ b) ? PHYAD : IDLE;
              rd_q    <= op_q;
              cnt_q   <= 4'd4;
            end
          end
          PHYAD: begin
            phy_q <= {phy_q[3:0], b};
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
              state_q <= REGAD;
              cnt_q   <= 4'd4;
            end
          end
          REGAD: begin
            reg_q <= reg_d;
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
              state_q <= TA;
              cnt_q   <= 4'd1;
              sh_q    <= rd_word;
            end
          end
          TA: begin
            cnt_q <= cnt_q - 4'd1;
            if (rd_q && match) begin
              MDIO_OE <= 1'b1;
              MDIO_O  <= cnt_q == 4'd0 ? sh_q[15] : 1'b0;
            end
            if (cnt_q == 4'd0) begin
              state_q <= rd_q ? RD_DATA : WR_DATA;
              cnt_q   <= 4'd15;
              sh_q    <= rd_q ? {sh_q[14:0], 1'b0} : sh_q;
            end
          end
          RD_DATA: begin
            cnt_q <= cnt_q - 4'd1;
            sh_q  <= {sh_q[14:0], 1'b0};
            if (match) MDIO_O <= sh_q[15];
            if (cnt_q == 4'd0) begin
              MDIO_OE <= 1'b0;
              MDIO_O  <= 1'b1;
              state_q <= IDLE;
            end
          end
          WR_DATA: begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
              state_q <= IDLE;
              if (match) begin
                Wr_Valid <= 1'b1;
                Wr_Addr  <= reg_q;
                Wr_Data  <= sh_d;
                if (reg_q != 5'd2 && reg_q != 5'd3) rf_q[reg_q] <= sh_d;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: station-side bench driving Clause 22 frames against a register-file model.
module tb_mdio_responder;
  logic        Clk = 1'b0, Rst = 1'b1, MDC = 1'b0, st_drv = 1'b1;
  logic        MDIO_O, MDIO_OE, Wr_Valid;
  logic [4:0]  Wr_Addr;
  logic [15:0] Wr_Data;
  wire         mdio_line = MDIO_OE ? MDIO_O : st_drv;
  int          tests = 0, fails = 0, wv_cnt = 0, half = 5, oe_acc = 0;
  logic        smp_line;
  logic [15:0] m_rf [32];

  mdio_responder #(.PHY_ADDR(5'd1), .PHY_ID1(16'h0022), .PHY_ID2(16'h1560)) dut (
    .Clk(Clk), .Rst(Rst), .MDC(MDC), .MDIO_I(mdio_line), .MDIO_O(MDIO_O),
    .MDIO_OE(MDIO_OE), .Wr_Valid(Wr_Valid), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data)
  );

  always #5 Clk = ~Clk;
  always @(negedge Clk) if (Wr_Valid === 1'b1) wv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 16'h0000;
    m_rf[2] = 16'h0022;
    m_rf[3] = 16'h1560;
  endtask

  // One MDC bit: the station drives after the fall and samples just before the rise.
  task automatic mdc_bit(input logic d);
    st_drv = d;
    repeat (half) @(negedge Clk);
    smp_line = mdio_line;
    if (MDIO_OE === 1'b1) oe_acc++;
    MDC = 1'b1;
    repeat (half) @(negedge Clk);
    MDC = 1'b0;
  endtask

  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd, input int rst_at,
                       output logic [15:0] rd, output int oe_n);
    logic [13:0] hdr;
    logic        is_rd;
    hdr    = {2'b01, op, pa, ra};
    is_rd  = op == 2'b10;
    oe_acc = 0;
    rd     = '0;
    mdc_bit(1'b0);
    repeat (pre) mdc_bit(1'b1);
    for (int i = 13; i >= 0; i--) mdc_bit(hdr[i]);
    mdc_bit(1'b1);
    mdc_bit(is_rd);
    for (int i = 15; i >= 0; i--) begin
      if (i == rst_at) begin
        check("oe_before_rst", {31'd0, MDIO_OE}, 32'd1);
        Rst = 1'b1;
        @(negedge Clk);
        check("oe_after_rst", {31'd0, MDIO_OE}, 32'd0);
        check("o_after_rst", {31'd0, MDIO_O}, 32'd1);
        Rst = 1'b0;
      end
      mdc_bit(is_rd ? 1'b1 : wd[i]);
      rd[i] = smp_line;
    end
    mdc_bit(1'b1);
    oe_n = oe_acc;
  endtask

  task automatic wr(input int pre, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
    int n0, oe;
    logic acc;
    logic [15:0] rd;
    n0  = wv_cnt;
    acc = pre >= 32 && pa == 5'd1;
    frame(pre, 2'b01, pa, ra, wd, -1, rd, oe);
    check("wr_oe_bits", oe, 0);
    check("wr_valid_cnt", wv_cnt - n0, {31'd0, acc});
    if (acc) begin
      check("wr_addr", {27'd0, Wr_Addr}, {27'd0, ra});
      check("wr_data", {16'd0, Wr_Data}, {16'd0, wd});
      if (ra != 5'd2 && ra != 5'd3) m_rf[ra] = wd;
    end
  endtask

  task automatic rdc(input logic [4:0] pa, input logic [4:0] ra);
    int oe;
    logic [15:0] rd;
    frame(32, 2'b10, pa, ra, 16'h0000, -1, rd, oe);
    if (pa == 5'd1) begin
      check("rd_data", {16'd0, rd}, {16'd0, m_rf[ra]});
      check("rd_oe_bits", oe, 17);
    end else check("rd_nomatch_oe_bits", oe, 0);
  endtask

  initial begin
    int oe, n0;
    logic [15:0] rd, d;
    logic [4:0] r;
    model_clear();
    repeat (5) @(negedge Clk);
    check("rst_oe", {31'd0, MDIO_OE}, 32'd0);
    check("rst_o", {31'd0, MDIO_O}, 32'd1);
    check("rst_wv", {31'd0, Wr_Valid}, 32'd0);
    check("rst_waddr", {27'd0, Wr_Addr}, 32'd0);
    check("rst_wdata", {16'd0, Wr_Data}, 32'd0);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    wr(32, 5'd1, 5'd5, 16'hA5C3);
    rdc(5'd1, 5'd5);
    rdc(5'd1, 5'd2);
    rdc(5'd1, 5'd3);
    wr(32, 5'd1, 5'd2, 16'hFFFF);
    rdc(5'd1, 5'd2);
    rdc(5'd7, 5'd5);
    wr(32, 5'd7, 5'd5, 16'h1234);
    rdc(5'd1, 5'd5);
    wr(31, 5'd1, 5'd6, 16'hBEEF);
    rdc(5'd1, 5'd6);
    wr(32, 5'd1, 5'd6, 16'h7E57);
    rdc(5'd1, 5'd6);
    n0 = wv_cnt;
    frame(32, 2'b11, 5'd1, 5'd5, 16'hFFFF, -1, rd, oe);
    check("op11_oe_bits", oe, 0);
    check("op11_no_write", wv_cnt - n0, 0);
    rdc(5'd1, 5'd5);
    for (int k = 0; k < 6; k++) begin
      half = (k % 2 == 1) ? 25 : 5;
      r = 5'($urandom_range(0, 31));
      d = 16'($urandom);
      wr(32, 5'd1, r, d);
      rdc(5'd1, r);
    end
    half = 5;
    wr(32, 5'd1, 5'd9, 16'h5A3C);
    frame(32, 2'b10, 5'd1, 5'd9, 16'h0000, 8, rd, oe);
    model_clear();
    check("postrst_waddr", {27'd0, Wr_Addr}, 32'd0);
    check("postrst_wdata", {16'd0, Wr_Data}, 32'd0);
    rdc(5'd1, 5'd9);
    rdc(5'd1, 5'd5);
    rdc(5'd1, 5'd2);
    wr(32, 5'd1, 5'd9, 16'hC0DE);
    rdc(5'd1, 5'd9);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: the Clause 22 PHY address this block answers to.
REQ-002 SHALL have parameter PHY_ID1, default 16'h0022: the read-only value of register 2.
REQ-003 SHALL have parameter PHY_ID2, default 16'h1560: the read-only value of register 3.
REQ-004 SHALL have port Clk  input  1  system clock; the only clock; frequency at least 10x MDC.
REQ-005 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port MDC  input  1  management clock from the station; asynchronous to Clk; sampled as data.
REQ-007 SHALL have port MDIO_I  input  1  MDIO line as seen at the pad; asynchronous.
REQ-008 SHALL have port MDIO_O  output  1  MDIO drive value.
REQ-009 SHALL have port MDIO_OE  output  1  MDIO drive enable; 1 = responder drives the line.
REQ-010 SHALL have port Wr_Valid  output  1  one-Clk pulse per completed write.
REQ-011 SHALL have port Wr_Addr  output  5  register address of the last write.
REQ-012 SHALL have port Wr_Data  output  16  data of the last write.

Function
REQ-013 SHALL synchronise MDC and MDIO_I through two Clk flops each, with identical depth, so both stay aligned.
REQ-014 SHALL detect an MDC rising edge (the "edge") from the synchronised MDC; all protocol actions occur only on the Clk cycle an edge is detected.
REQ-015 SHALL sample the synchronised MDIO_I on each edge and SHALL update MDIO_O/MDIO_OE on that same cycle, within 4 Clk cycles of the pad MDC rise.
REQ-016 SHALL implement states IDLE, ST, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA.
REQ-017 IDLE: a saturating 6-bit counter counts consecutive sampled 1s; a sampled 0 with count < 32 clears the counter; a sampled 0 with count >= 32 is ST bit 0 -> ST.
REQ-018 ST: sampled 1 -> OP; sampled 0 -> IDLE with the counter cleared.
REQ-019 OP: capture 2 bits MSB first; 10 = read, 01 = write; 00/11 -> IDLE after the second bit.
REQ-020 PHYAD then REGAD: capture 5 bits each, MSB first; after the last REGAD bit -> TA.
REQ-021 Address match: the captured PHYAD equals PHY_ADDR. On a mismatch, MDIO_OE SHALL stay 0 for the whole frame, and no write SHALL occur.
REQ-022 Read with match, TA: on the edge sampling TA bit 1, set MDIO_OE=1 and MDIO_O=0; on the edge sampling TA bit 2, drive data bit 15 and enter RD_DATA.
REQ-023 RD_DATA: on each subsequent edge, drive the next lower bit; on the edge after bit 0 is driven, set MDIO_OE=0 and MDIO_O=1, then -> IDLE.
REQ-024 Read data SHALL be latched at TA entry: register 2 = PHY_ID1, register 3 = PHY_ID2, others = the register file contents.
REQ-025 Write: TA bits are sampled but not checked; -> WR_DATA; shift 16 bits MSB first.
REQ-026 On the 16th write data bit with a match:
  - update register REGAD, except registers 2 and 3, which ignore writes;
  - load Wr_Addr and Wr_Data;
  - pulse Wr_Valid for 1 Clk. The pulse SHALL also occur for writes to registers 2/3.
REQ-027 After any frame end or abort, the IDLE counter SHALL restart from 0, so a new preamble of >= 32 ones is required.
REQ-028 The register file SHALL be 32 x 16 bits, with reset value 0 except the read-only registers 2/3.
REQ-029 MDIO_OE SHALL be 1 only in TA bit 2 and RD_DATA of a matched read.

Reset
REQ-030 While Rst=1:
  - state = IDLE and the counter = 0;
  - MDIO_OE=0, MDIO_O=1;
  - Wr_Valid=0, Wr_Addr=0, Wr_Data=0;
  - all writable registers = 0 and the synchroniser flops = 0.
REQ-031 Rst asserted mid-frame SHALL abort the frame within the same cycle as the reset Clk edge. After release, the block SHALL wait for a full preamble.

Verification
REQ-032 Write 16'hA5C3 to register 5 at PHY_ADDR=1, then read register 5 -> Wr_Valid pulses once with Wr_Addr=5, Wr_Data=A5C3; the read returns A5C3 with OE high for exactly 17 MDC bits.
REQ-033 Read register 2 and register 3 -> 16'h0022 and 16'h1560; a write of 16'hFFFF to register 2 -> Wr_Valid pulses, and a re-read returns 0022.
REQ-034 Read at PHYAD=7 -> MDIO_OE remains 0 throughout; a write at PHYAD=7 -> no Wr_Valid, and register content is unchanged.
REQ-035 Preamble of 31 ones followed by a valid frame -> ignored; 32 ones followed by the frame -> accepted; OP=11 -> frame dropped with OE=0.
REQ-036 Rst pulse during RD_DATA bit 8 -> OE=0 on the next Clk; the register file is cleared; the next full frame is served correctly.
REQ-037 Back-to-back frames with MDC/Clk ratio 1:10 and 1:50, each with a fresh preamble -> all transactions are correct.
